// File: rtl/dht_sensor_reader.sv
// ---------------------------------------------------------------------------
// dht_sensor_reader
//
// Master side of a DHT11-style single-wire sensor link. Produces the 8-bit
// humidity byte used by the humidity controller, plus the temperature byte.
//
// The controller issues the host start-low pulse and waits for the sensor
// response. It then decodes the 40-bit frame (MSB first) by measuring the
// width of each high phase, and finally verifies the byte checksum.
//
// The pin tristate lives outside this block: dq_oe=1 pulls the line low,
// and dq_in is the raw (asynchronous) line level.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   start        in   single-cycle read request (ignored while busy)
//   dq_in        in   raw sensor line level, asynchronous
//   dq_oe        out  1 = drive line low, 0 = release
//   busy         out  high from accepted start until return to IDLE
//   humidity_out out  integer humidity byte of the last good frame
//   temp_out     out  integer temperature byte of the last good frame
//   data_valid   out  one-cycle pulse on a good frame
//   checksum_err out  one-cycle pulse on a checksum mismatch
//   timeout_err  out  one-cycle pulse on an edge timeout
//
// Optional feature (compile-time macro DHT_AUTO_POLL_EN):
//   When defined, a read is also triggered internally once the controller
//   has been idle for POLL_PERIOD_US microseconds. This covers both the
//   time since reset release and the time since the previous return to
//   IDLE. When undefined, reads happen only on the start port.
// ---------------------------------------------------------------------------
module dht_sensor_reader #(
  parameter int TICKS_PER_US   = 50,
  parameter int START_LOW_US   = 18000,
  parameter int BIT_THRESH_US  = 40,
  parameter int TIMEOUT_US     = 200,
  parameter int POLL_PERIOD_US = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       busy,
  output logic [7:0] humidity_out,
  output logic [7:0] temp_out,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err
);

  // The microsecond timer has to hold the longest interval it is compared
  // against.
  localparam int SPAN_A_US = (START_LOW_US > POLL_PERIOD_US) ? START_LOW_US : POLL_PERIOD_US;
  localparam int SPAN_B_US = (TIMEOUT_US > BIT_THRESH_US) ? TIMEOUT_US : BIT_THRESH_US;
  localparam int SPAN_US   = (SPAN_A_US > SPAN_B_US) ? SPAN_A_US : SPAN_B_US;
  localparam int TW        = $clog2(SPAN_US + 1);
  localparam int PW        = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};
  localparam logic [TW-1:0] START_T    = TW'(START_LOW_US);
  localparam logic [TW-1:0] THRESH_T   = TW'(BIT_THRESH_US);
  localparam logic [TW-1:0] TIMEOUT_T  = TW'(TIMEOUT_US);
`ifdef DHT_AUTO_POLL_EN
  localparam logic [TW-1:0] POLL_T     = TW'(POLL_PERIOD_US);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_LOW = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_CHECK     = 3'd7
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nx_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_inc_s;
  logic [5:0]    bit_cnt_r;
  logic [39:0]   shift_r;
  logic          us_tick_s;
  logic          timeout_hit_s;
  logic          bit_val_s;
  logic          start_req_s;
  logic          dq_meta_r;
  logic          dq_sync_r;
  logic          dq_prev_r;
  logic          rise_s;
  logic          fall_s;

  // Sum of the four data bytes, modulo 256, as carried in the fifth byte.
  function automatic logic [7:0] frame_sum(input logic [39:0] frame);
    frame_sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  endfunction

  // States in which the controller waits for the sensor to move the line.
  function automatic logic is_edge_wait(input state_t s);
    case (s)
      S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: is_edge_wait = 1'b1;
      default:                                                     is_edge_wait = 1'b0;
    endcase
  endfunction

  // Two-flop synchronizer plus a one-cycle history flop for edge detection.
  // The flops reset high so that an idle, pulled-up line shows no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_meta_r <= 1'b1;
      dq_sync_r <= 1'b1;
      dq_prev_r <= 1'b1;
    end else begin
      dq_meta_r <= dq_in;
      dq_sync_r <= dq_meta_r;
      dq_prev_r <= dq_sync_r;
    end
  end

  assign rise_s = dq_sync_r & ~dq_prev_r;
  assign fall_s = ~dq_sync_r & dq_prev_r;

  // Prescaler wrap, saturating timer increment, and derived decisions.
  // Bit and timeout decisions use the timer value including this cycle's
  // tick. As a result, a high phase of N us measures exactly N.
  always_comb begin
    us_tick_s = (presc_r == PRESC_LAST);
    if (us_tick_s) begin
      presc_nx_s = {PW{1'b0}};
    end else begin
      presc_nx_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
    if (us_tick_s && (timer_r != TIMER_SAT)) begin
      timer_inc_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      timer_inc_s = timer_r;
    end
    timeout_hit_s = (timer_inc_s >= TIMEOUT_T);
    bit_val_s     = (timer_inc_s > THRESH_T);
`ifdef DHT_AUTO_POLL_EN
    // The timer restarts on entry to IDLE, so in IDLE it measures idle time.
    start_req_s = start | ((state_r == S_IDLE) && (timer_inc_s >= POLL_T));
`else
    start_req_s = start;
`endif
  end

  // Next-state decode; the timeout always wins over a coincident edge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_req_s) state_nx_s = S_START_LOW;
        else             state_nx_s = S_IDLE;
      end
      S_START_LOW: begin
        if (timer_inc_s >= START_T) state_nx_s = S_WAIT_RESP;
        else                        state_nx_s = S_START_LOW;
      end
      S_WAIT_RESP: begin
        if (timeout_hit_s) state_nx_s = S_IDLE;
        else if (fall_s)   state_nx_s = S_RESP_LOW;
        else               state_nx_s = S_WAIT_RESP;
      end
      S_RESP_LOW: begin
        if (timeout_hit_s) state_nx_s = S_IDLE;
        else if (rise_s)   state_nx_s = S_RESP_HIGH;
        else               state_nx_s = S_RESP_LOW;
      end
      S_RESP_HIGH: begin
        if (timeout_hit_s) state_nx_s = S_IDLE;
        else if (fall_s)   state_nx_s = S_BIT_LOW;
        else               state_nx_s = S_RESP_HIGH;
      end
      S_BIT_LOW: begin
        if (timeout_hit_s) state_nx_s = S_IDLE;
        else if (rise_s)   state_nx_s = S_BIT_HIGH;
        else               state_nx_s = S_BIT_LOW;
      end
      S_BIT_HIGH: begin
        if (timeout_hit_s) begin
          state_nx_s = S_IDLE;
        end else if (fall_s) begin
          if (bit_cnt_r == 6'd39) state_nx_s = S_CHECK;
          else                    state_nx_s = S_BIT_LOW;
        end else begin
          state_nx_s = S_BIT_HIGH;
        end
      end
      S_CHECK: state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Protocol FSM: state, timebase, frame capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      presc_r      <= {PW{1'b0}};
      timer_r      <= {TW{1'b0}};
      bit_cnt_r    <= 6'd0;
      shift_r      <= 40'd0;
      dq_oe        <= 1'b0;
      busy         <= 1'b0;
      humidity_out <= 8'd0;
      temp_out     <= 8'd0;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      // The prescaler restarts together with the timer. This keeps each
      // width measurement independent of the free-running tick phase.
      if (state_nx_s != state_r) begin
        presc_r <= {PW{1'b0}};
        timer_r <= {TW{1'b0}};
      end else begin
        presc_r <= presc_nx_s;
        timer_r <= timer_inc_s;
      end

      dq_oe        <= (state_nx_s == S_START_LOW);
      busy         <= (state_nx_s != S_IDLE);
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      // In the edge-wait states, the only exit to IDLE is a timeout.
      timeout_err  <= is_edge_wait(state_r) && (state_nx_s == S_IDLE);

      case (state_r)
        S_RESP_HIGH: begin
          if (state_nx_s == S_BIT_LOW) bit_cnt_r <= 6'd0;
        end
        S_BIT_HIGH: begin
          if ((state_nx_s == S_BIT_LOW) || (state_nx_s == S_CHECK)) begin
            shift_r   <= {shift_r[38:0], bit_val_s};
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end
        end
        S_CHECK: begin
          // Bytes 1 and 3 (decimal parts) only take part in the checksum.
          if (frame_sum(shift_r) == shift_r[7:0]) begin
            humidity_out <= shift_r[39:32];
            temp_out     <= shift_r[23:16];
            data_valid   <= 1'b1;
          end else begin
            checksum_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/dht_sensor_reader.md
Name: dht_sensor_reader

Overview:
- Front end that produces the 8-bit humidity value consumed by the humidity controller.
- Runs the master side of a DHT11-style single-wire protocol: issues the start pulse, decodes the sensor's 40-bit frame and verifies the checksum.
- Presents humidity and temperature bytes with a one-cycle valid strobe.
- Pin tristate is external: the block drives dq_oe (1 = pull line low) and samples dq_in.

Parameters:
- TICKS_PER_US, 50, clk cycles per microsecond; generates the internal 1 µs tick.
- START_LOW_US, 18000, duration of the host start-low pulse in µs.
- BIT_THRESH_US, 40, bit decision: high width > BIT_THRESH_US gives 1, otherwise 0.
- TIMEOUT_US, 200, maximum µs spent in any wait-for-edge state.
- POLL_PERIOD_US, 2000000, auto-poll interval; used only with DHT_AUTO_POLL_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle read request
- dq_in  in  1  raw sensor line level (asynchronous)
- dq_oe  out  1  1 = drive line low; 0 = release
- busy  out  1  high from accepted start until return to IDLE
- humidity_out  out  8  integer humidity byte of last good frame
- temp_out  out  8  integer temperature byte of last good frame
- data_valid  out  1  one-cycle pulse on good frame
- checksum_err  out  1  one-cycle pulse on checksum mismatch
- timeout_err  out  1  one-cycle pulse on edge timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs are 0, and dq_oe=0.
  - State is IDLE; prescaler, µs timer and bit counter are cleared.
  - Reset mid-frame aborts the frame immediately; dq_oe is 0 from the next edge.
- Input path:
  - dq_in passes through a 2-flop synchronizer.
  - Edges are detected on the synchronized signal. Total input latency is 2 cycles, plus 1 cycle for the edge flag.
- Timing:
  - The prescaler counts 0..TICKS_PER_US-1 and pulses us_tick at wrap.
  - The µs timer clears on every state change and increments on us_tick.
  - Timer width is sized for max(START_LOW_US, POLL_PERIOD_US).
- States:
  - IDLE: start=1 goes to START_LOW with busy=1. start while busy is ignored.
  - START_LOW: dq_oe=1 for START_LOW_US µs, then dq_oe=0 and go to WAIT_RESP.
  - WAIT_RESP: falling edge goes to RESP_LOW.
  - RESP_LOW: rising edge goes to RESP_HIGH.
  - RESP_HIGH: falling edge goes to BIT_LOW; the 40-bit counter is cleared.
  - BIT_LOW: rising edge goes to BIT_HIGH.
  - BIT_HIGH: on falling edge:
    - shift bit (timer > BIT_THRESH_US) into the 40-bit register, MSB first;
    - increment the bit counter;
    - if count = 40 go to CHECK, else go to BIT_LOW.
  - CHECK: one cycle. Bytes b0..b4 are received order.
    - If (b0+b1+b2+b3) mod 256 == b4: humidity_out<=b0, temp_out<=b2, data_valid=1.
    - Else: checksum_err=1 and outputs hold.
    - Then go to IDLE with busy=0 on the same edge.
- Timeout: in WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, timer reaching TIMEOUT_US gives:
  - timeout_err=1 for one cycle;
  - go to IDLE, dq_oe=0, data outputs hold.
- Edge cases:
  - A last bit ending exactly on the timeout tick counts as a timeout; the timeout check has priority over the edge.
  - Bytes b1/b3 (decimal parts) are checksummed but not output.
- The pulse outputs (data_valid, checksum_err, timeout_err) are mutually exclusive and never last more than one cycle.

Optional Feature:
- Macro: DHT_AUTO_POLL_EN.
- Defined:
  - An internal µs counter fires an internal start every POLL_PERIOD_US µs, measured from the previous return to IDLE.
  - The start port is still honoured. An internal trigger while busy is dropped.
  - The first auto read occurs POLL_PERIOD_US after reset release.
- Undefined: reads occur only on the start port, and no poll counter logic exists.

Test Plan:
- Bench setup for all cases: TICKS_PER_US=2, START_LOW_US=20, TIMEOUT_US=200, with a sensor model.
- start, model sends 0x37,0x00,0x19,0x00,0x50 (1-bit high 70 µs, 0-bit high 26 µs) -> dq_oe high 20 µs; humidity_out=0x37, temp_out=0x19; data_valid exactly 1 cycle; busy falls on the same edge.
- Same frame with b4=0x51 -> checksum_err one pulse; humidity_out/temp_out keep their prior values; data_valid stays 0.
- start, model never responds -> timeout_err pulses 200 µs after dq_oe release; busy=0; outputs unchanged.
- Bit-threshold boundary: high widths of 40 µs and 41 µs -> decoded 0 and 1 respectively; a frame 0x00,0x00,0x00,0x01,0x01 built from these decodes correctly.
- Second start pulse mid-frame -> ignored, frame completes normally. rst=1 asserted during bit 17 -> next cycle dq_oe=0, busy=0, all outputs 0, and a fresh start succeeds.
- With DHT_AUTO_POLL_EN and POLL_PERIOD_US=500 -> reads begin 500 µs after reset release without any start, and again 500 µs after each return to IDLE.
